// File: rtl/fp_add_uc.sv
// -----------------------------------------------------------------------------
// fp_add_uc -- control unit for the single-precision floating-point adder
// datapath (fd). It sequences exponent compare, align/add, normalize, round
// and an optional renormalize pass, and drives every sinal* control input of
// the datapath.
//
// Optional feature (compile-time macro FP_SPECIAL_CASES_EN):
//   When defined, an operand with exponent field 255 or a +/-0 operand skips
//   the arithmetic stages. COMPARE jumps to DONE and raises especial with
//   pronto. When undefined, especial is tied to 0 and every operand takes the
//   normal path.
//
// Parameters:
//   FRAC_W  width of ula/round_fract. Bit 26 carry, bit 25 hidden one,
//           bits 24:2 fraction, bits 1:0 guard/sticky.
//   EXP_W   exponent width.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   iniciar          in   start pulse, sampled only in IDLE
//   operando_a/b     in   IEEE-754 single-precision operands
//   ula              in   adder output read back from the datapath
//   round_fract      in   rounded fraction read back from the datapath
//   sinalMuxFP1      out  0 first pass, 1 renormalize loop
//   sinalMuxFP2      out  1 when |B| > |A|
//   sinalMuxFP3      out  1 when B is the fraction to shift (~sinalMuxFP2)
//   sinalMuxFP4      out  exponent source: 0 aligned, 1 rounded
//   sinalMuxFP5      out  fraction source: 0 ula, 1 round_fract
//   sinalOp          out  0 add, 1 subtract
//   sinalShiftFract  out  alignment right-shift amount
//   sinalShiftRes    out  [8] 1 right / 0 left, [7:0] amount
//   sinalIncOrDec    out  [8] 1 decrement / 0 increment, [7:0] amount
//   sinalRound       out  round-enable strobe, high during ROUND
//   ocupado          out  high in every state except IDLE
//   pronto           out  one-cycle done pulse
//   overflow         out  exponent overflow, valid with pronto
//   underflow        out  exponent underflow, valid with pronto
//   especial         out  special operand detected
//   state_dbg        out  current FSM state
//
// Handshake: iniciar is accepted only while ocupado = 0 (IDLE); the operands
// are captured on that clock edge. Pulses of iniciar while ocupado = 1 are
// dropped, nothing is queued. pronto is high for exactly one cycle (the DONE
// state); overflow/underflow/especial are meaningful only in that cycle.
//
// Timing model: decisions that depend on the datapath (compare, normalize,
// renormalize check) are taken at the edge that ends their state, so the
// resulting controls are visible from the next state on. Strobes that belong
// to a state (sinalRound, the RENORM mux selects, pronto) are registered on
// entry so they are high while the FSM sits in that state.
// -----------------------------------------------------------------------------
module fp_add_uc #(
    parameter int FRAC_W = 27,
    parameter int EXP_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [31:0]       operando_a,
    input  logic [31:0]       operando_b,
    input  logic [FRAC_W-1:0] ula,
    input  logic [FRAC_W-1:0] round_fract,
    output logic              sinalMuxFP1,
    output logic              sinalMuxFP2,
    output logic              sinalMuxFP3,
    output logic              sinalMuxFP4,
    output logic              sinalMuxFP5,
    output logic              sinalOp,
    output logic [7:0]        sinalShiftFract,
    output logic [8:0]        sinalShiftRes,
    output logic [8:0]        sinalIncOrDec,
    output logic              sinalRound,
    output logic              ocupado,
    output logic              pronto,
    output logic              overflow,
    output logic              underflow,
    output logic              especial,
    output logic [2:0]        state_dbg
);

    // Exponent arithmetic runs two bits wider than the field and signed so
    // that both >= 255 and <= 0 can be seen after increments/decrements.
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONE  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_OVF  = {2'b00, {EXP_W{1'b1}}};
    localparam logic [7:0]           SHIFT_SAT = 8'(FRAC_W);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_ADD       = 3'd2,
        S_NORMALIZE = 3'd3,
        S_ROUND     = 3'd4,
        S_CHECK     = 3'd5,
        S_RENORM    = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                state;
    logic [31:0]           op_a_q;
    logic [31:0]           op_b_q;
    logic signed [XW-1:0]  exp_q;
    logic                  result_zero;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Magnitude compare and alignment amount from the latched operands.
    // Exponent and fraction sit next to each other in the IEEE layout, so
    // comparing bits [30:0] compares magnitudes directly.
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] exp_big;
    logic [EXP_W-1:0] exp_small;
    logic [EXP_W-1:0] exp_diff;
    logic [7:0]       align_amt;
    logic             b_larger;

    always_comb begin
        exp_a     = op_a_q[30:23];
        exp_b     = op_b_q[30:23];
        b_larger  = (op_b_q[30:0] > op_a_q[30:0]);
        exp_big   = b_larger ? exp_b : exp_a;
        exp_small = b_larger ? exp_a : exp_b;
        // The larger magnitude always has the larger-or-equal exponent, so
        // this difference cannot go negative.
        exp_diff  = exp_big - exp_small;
        align_amt = (exp_diff > SHIFT_SAT) ? SHIFT_SAT : exp_diff;
    end

`ifdef FP_SPECIAL_CASES_EN
    logic special_hit;
    always_comb begin
        special_hit = (exp_a == {EXP_W{1'b1}}) || (exp_b == {EXP_W{1'b1}}) ||
                      (op_a_q[30:0] == 31'd0)  || (op_b_q[30:0] == 31'd0);
    end
`endif

    // ------------------------------------------------------------------
    // Leading-zero count of ula starting at the hidden-one position.
    // Only consulted when ula[26] = 0 and ula != 0, so a one is always
    // found somewhere in [25:0] and the result stays within 0..25.
    // ------------------------------------------------------------------
    logic [4:0] lz;
    logic       lz_found;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = FRAC_W - 2; i >= 0; i--) begin
            if (!lz_found) begin
                if (ula[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + 5'd1;
                end
            end
        end
    end

    logic signed [XW-1:0] exp_minus_lz;
    assign exp_minus_lz = exp_q - $signed({{(XW-5){1'b0}}, lz});

    // Only the carry bit of the rounded fraction steers the FSM.
    logic unused_round_bits;
    assign unused_round_bits = ^round_fract[FRAC_W-2:0];

    // ------------------------------------------------------------------
    // Main FSM with registered control outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            op_a_q          <= '0;
            op_b_q          <= '0;
            exp_q           <= '0;
            result_zero     <= 1'b0;
            sinalMuxFP1     <= 1'b0;
            sinalMuxFP2     <= 1'b0;
            sinalMuxFP3     <= 1'b0;
            sinalMuxFP4     <= 1'b0;
            sinalMuxFP5     <= 1'b0;
            sinalOp         <= 1'b0;
            sinalShiftFract <= '0;
            sinalShiftRes   <= '0;
            sinalIncOrDec   <= '0;
            sinalRound      <= 1'b0;
            ocupado         <= 1'b0;
            pronto          <= 1'b0;
            overflow        <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iniciar) begin
                        op_a_q  <= operando_a;
                        op_b_q  <= operando_b;
                        ocupado <= 1'b1;
                        state   <= S_COMPARE;
                    end
                end

                S_COMPARE: begin
`ifdef FP_SPECIAL_CASES_EN
                    if (special_hit) begin
                        // Special operands bypass the datapath: no shift,
                        // round or exponent-adjust controls are left active.
                        sinalShiftFract <= '0;
                        sinalShiftRes   <= '0;
                        sinalIncOrDec   <= '0;
                        sinalRound      <= 1'b0;
                        pronto          <= 1'b1;
                        overflow        <= 1'b0;
                        underflow       <= 1'b0;
                        state           <= S_DONE;
                    end else begin
`else
                    begin
`endif
                        sinalMuxFP2     <= b_larger;
                        sinalMuxFP3     <= ~b_larger;
                        sinalShiftFract <= align_amt;
                        sinalOp         <= op_a_q[31] ^ op_b_q[31];
                        exp_q           <= $signed({2'b00, exp_big});
                        result_zero     <= 1'b0;
                        state           <= S_ADD;
                    end
                end

                S_ADD: begin
                    // Controls are held so ula settles before NORMALIZE
                    // looks at it.
                    state <= S_NORMALIZE;
                end

                S_NORMALIZE: begin
                    if (ula[FRAC_W-1]) begin
                        // Carry out: one right shift, exponent + 1.
                        sinalShiftRes <= 9'b1_0000_0001;
                        sinalIncOrDec <= 9'b0_0000_0001;
                        exp_q         <= exp_q + EXP_ONE;
                    end else if (ula == '0) begin
                        // Exact cancellation: result is zero, exponent 0.
                        sinalShiftRes <= 9'b0_0000_0000;
                        sinalIncOrDec <= 9'b1_0000_0000;
                        exp_q         <= EXP_ZERO;
                        result_zero   <= 1'b1;
                    end else begin
                        sinalShiftRes <= {4'b0000, lz};
                        // Already normalised (lz = 0) is expressed as
                        // "increment by zero" rather than "decrement by zero".
                        sinalIncOrDec <= (lz == 5'd0) ? 9'd0 : {4'b1000, lz};
                        exp_q         <= exp_minus_lz;
                    end
                    sinalRound <= 1'b1;
                    state      <= S_ROUND;
                end

                S_ROUND: begin
                    sinalRound <= 1'b0;
                    state      <= S_CHECK;
                end

                S_CHECK: begin
                    if (round_fract[FRAC_W-1]) begin
                        // Rounding carried into bit 26: loop the result
                        // back through the shifter once more.
                        sinalMuxFP1   <= 1'b1;
                        sinalMuxFP4   <= 1'b1;
                        sinalMuxFP5   <= 1'b1;
                        sinalShiftRes <= 9'b1_0000_0001;
                        sinalIncOrDec <= 9'b0_0000_0001;
                        exp_q         <= exp_q + EXP_ONE;
                        state         <= S_RENORM;
                    end else begin
                        pronto    <= 1'b1;
                        overflow  <= (exp_q >= EXP_OVF);
                        underflow <= (exp_q <= EXP_ZERO) && !result_zero;
                        state     <= S_DONE;
                    end
                end

                S_RENORM: begin
                    pronto    <= 1'b1;
                    overflow  <= (exp_q >= EXP_OVF);
                    underflow <= (exp_q <= EXP_ZERO) && !result_zero;
                    state     <= S_DONE;
                end

                S_DONE: begin
                    pronto      <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    ocupado     <= 1'b0;
                    sinalMuxFP1 <= 1'b0;
                    sinalMuxFP4 <= 1'b0;
                    sinalMuxFP5 <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_SPECIAL_CASES_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            especial <= 1'b0;
        end else if (state == S_COMPARE && special_hit) begin
            especial <= 1'b1;
        end else if (state == S_DONE) begin
            especial <= 1'b0;
        end
    end
`else
    assign especial = 1'b0;
`endif

endmodule
